// File: rtl/s1_frame_tx.sv
// s1_frame_tx: loads an 18x8 source bank, transposes it into eight 21-bit
// frames and shifts them out MSB first on sen/sd with a paced inter-frame gap.
module s1_frame_tx #(
  parameter int unsigned NWORD  = 18,
  parameter int unsigned NFRAME = 8,
  parameter int unsigned GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              RB1_RW,
  output logic [4:0]        RB1_A,
  input  logic [NFRAME-1:0] RB1_Q,
  input  logic              hold,
  output logic              sen,
  output logic              sd,
  output logic              S1_done
);

  localparam int unsigned AW  = 5;
  localparam int unsigned FIW = 3;
  localparam int unsigned FW  = FIW + NWORD;
  localparam int unsigned BW  = 5;
  localparam int unsigned GW  = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_TX   = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                       state_q,    state_d;
  logic [NWORD-1:0][NFRAME-1:0] wbuf_q,     wbuf_d;
  logic [AW-1:0]                load_cnt_q, load_cnt_d;
  logic [AW-1:0]                rb1_a_q,    rb1_a_d;
  logic [FIW-1:0]               frame_q,    frame_d;
  logic [BW-1:0]                bit_cnt_q,  bit_cnt_d;
  logic [GW-1:0]                gap_cnt_q,  gap_cnt_d;
  logic                         sen_q,      sen_d;
  logic                         sd_q,       sd_d;
  logic                         done_q,     done_d;
  logic                         rw_q,       rw_d;

  logic [FW-1:0]                cur_frame_c;
  logic [FW-1:0]                nxt_frame_c;

  // Frame f = {f, D17..D0} where data bit w is bit f of buffered word w.
  function automatic logic [FW-1:0] build_frame(
    input logic [NWORD-1:0][NFRAME-1:0] words,
    input logic [FIW-1:0]               f
  );
    logic [FW-1:0] fr;
    fr = '0;
    fr[FW-1 -: FIW] = f;
    for (int w = 0; w < int'(NWORD); w++) begin
      fr[w] = words[w][f];
    end
    return fr;
  endfunction

  // Frame currently shifting and the one the gap will launch next.
  always_comb begin
    cur_frame_c = build_frame(wbuf_q, frame_q);
    nxt_frame_c = build_frame(wbuf_q, frame_q + FIW'(1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    wbuf_d     = wbuf_q;
    load_cnt_d = load_cnt_q;
    rb1_a_d    = rb1_a_q;
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    sen_d      = 1'b1;
    sd_d       = 1'b0;
    done_d     = done_q;
    rw_d       = 1'b1;

    case (state_q)
      ST_LOAD: begin
        wbuf_d[load_cnt_q] = RB1_Q;
        // Address runs one ahead of the capture slot and parks on the last word.
        if (load_cnt_q >= AW'(NWORD - 2)) begin
          rb1_a_d = AW'(NWORD - 1);
        end else begin
          rb1_a_d = load_cnt_q + AW'(1);
        end
        if (load_cnt_q == AW'(NWORD - 1)) begin
          state_d   = ST_TX;
          frame_d   = '0;
          bit_cnt_d = BW'(FW - 1);
        end else begin
          load_cnt_d = load_cnt_q + AW'(1);
        end
      end

      ST_TX: begin
        sen_d = 1'b0;
        sd_d  = cur_frame_c[bit_cnt_q];
        if (bit_cnt_q == '0) begin
          gap_cnt_d = '0;
          state_d   = (frame_q == FIW'(NFRAME - 1)) ? ST_DONE : ST_GAP;
        end else begin
          bit_cnt_d = bit_cnt_q - BW'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q < GW'(GAP)) begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end else if (!hold) begin
          // First bit of the next frame goes out on the launching edge.
          state_d   = ST_TX;
          frame_d   = frame_q + FIW'(1);
          sen_d     = 1'b0;
          sd_d      = nxt_frame_c[FW-1];
          bit_cnt_d = BW'(FW - 2);
        end
      end

      ST_DONE: begin
        done_d = 1'b1;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State and output registers; reset clears everything including the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      wbuf_q     <= '0;
      load_cnt_q <= '0;
      rb1_a_q    <= '0;
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      sen_q      <= 1'b1;
      sd_q       <= 1'b0;
      done_q     <= 1'b0;
      rw_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      wbuf_q     <= wbuf_d;
      load_cnt_q <= load_cnt_d;
      rb1_a_q    <= rb1_a_d;
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      sen_q      <= sen_d;
      sd_q       <= sd_d;
      done_q     <= done_d;
      rw_q       <= rw_d;
    end
  end

  assign RB1_RW  = rw_q;
  assign RB1_A   = rb1_a_q;
  assign sen     = sen_q;
  assign sd      = sd_q;
  assign S1_done = done_q;

endmodule

// File: tb/tb_s1_frame_tx.sv
// Bench for s1_frame_tx: timeline model of expected outputs per edge,
// per-cycle compare, plus literal frame/timing expectations.
module tb_s1_frame_tx;

  localparam int NW   = 18;
  localparam int NF   = 8;
  localparam int GP   = 1;
  localparam int MAXE = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       rb1_rw;
  logic [4:0] rb1_a;
  logic [7:0] rb1_q;
  logic       hold;
  logic       sen;
  logic       sd;
  logic       s1_done;

  logic [7:0] mem [NW];

  // Source bank: read data follows the presented address.
  assign rb1_q = (rb1_a < 5'(NW)) ? mem[rb1_a] : 8'h00;

  always #5 clk = ~clk;

  s1_frame_tx #(.NWORD(NW), .NFRAME(NF), .GAP(GP)) dut (
    .clk     (clk),
    .rst     (rst),
    .RB1_RW  (rb1_rw),
    .RB1_A   (rb1_a),
    .RB1_Q   (rb1_q),
    .hold    (hold),
    .sen     (sen),
    .sd      (sd),
    .S1_done (s1_done)
  );

  int vectors     = 0;
  int miscompares = 0;

  bit          hold_at  [MAXE];
  bit          exp_sen  [MAXE];
  bit          exp_sd   [MAXE];
  bit          exp_done [MAXE];
  int          exp_a    [MAXE];
  logic [20:0] model_frame [NF];
  int          model_done_edge;
  int          model_start [NF];
  int          last_edge;

  logic [20:0] rx_frame [NF];
  int          rx_start [NF];
  int          rx_cnt;
  int          dut_done_edge;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic clear_hold();
    for (int i = 0; i < MAXE; i++) hold_at[i] = 1'b0;
  endtask

  // Expected per-edge outputs: load window, then frames separated by the
  // gap plus one extra idle cycle for each hold seen at a launch edge.
  task automatic build_model();
    int e;
    logic [20:0] w;
    for (int i = 0; i < MAXE; i++) begin
      exp_sen[i]  = 1'b1;
      exp_sd[i]   = 1'b0;
      exp_done[i] = 1'b0;
      exp_a[i]    = NW - 1;
    end
    exp_a[0] = 0;
    for (int k = 1; k <= NW; k++) exp_a[k] = (k < NW - 1) ? k : NW - 1;
    e = NW + 1;
    for (int f = 0; f < NF; f++) begin
      w = {3'(f), 18'h0};
      for (int wd = 0; wd < NW; wd++) w[wd] = mem[wd][f];
      model_frame[f] = w;
      model_start[f] = e;
      for (int b = 20; b >= 0; b--) begin
        exp_sen[e] = 1'b0;
        exp_sd[e]  = w[b];
        e++;
      end
      if (f < NF - 1) begin
        e += GP;
        while (hold_at[e]) e++;
      end
    end
    model_done_edge = e;
    for (int i = e; i < MAXE; i++) exp_done[i] = 1'b1;
    last_edge = e + 4;
  endtask

  task automatic check_reset(input string name);
    check(name, 64'({rb1_rw, rb1_a, sen, sd, s1_done}),
          64'({1'b1, 5'd0, 1'b1, 1'b0, 1'b0}));
  endtask

  // Reset, release, then compare every cycle and collect frames off the wire.
  // abort_at > 0 pulls reset low just after that edge.
  task automatic run(input int abort_at);
    logic        prev_sen;
    logic [20:0] cur;
    rst  = 1'b0;
    hold = 1'b0;
    rx_cnt = 0;
    dut_done_edge = 0;
    for (int f = 0; f < NF; f++) begin
      rx_frame[f] = 'x;
      rx_start[f] = 0;
    end
    repeat (2) @(posedge clk);
    #1 check_reset("reset state");
    @(negedge clk);
    rst  = 1'b1;
    hold = hold_at[1];
    prev_sen = 1'b1;
    cur = '0;
    for (int e = 1; e <= last_edge; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("edge %0d {sen,sd,done,rw,a}", e),
            64'({sen, sd, s1_done, rb1_rw, rb1_a}),
            64'({exp_sen[e], exp_sd[e], exp_done[e], 1'b1, 5'(exp_a[e])}));
      if (s1_done === 1'b1 && dut_done_edge == 0) dut_done_edge = e;
      if (sen === 1'b0) begin
        if (prev_sen) begin
          cur = '0;
          if (rx_cnt < NF) rx_start[rx_cnt] = e;
        end
        cur = {cur[19:0], sd};
      end else if (!prev_sen && rx_cnt < NF) begin
        rx_frame[rx_cnt] = cur;
        rx_cnt++;
      end
      prev_sen = sen;
      hold = hold_at[e + 1];
      if (e == abort_at) begin
        #2 rst = 1'b0;
        #1 check_reset("async reset mid-frame");
        return;
      end
    end
  endtask

  initial begin
    rst  = 1'b0;
    hold = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = 8'h00;
    clear_hold();

    // All words FF: every frame carries {f, 3FFFF}.
    for (int i = 0; i < NW; i++) mem[i] = 8'hFF;
    build_model();
    run(0);
    for (int f = 0; f < NF; f++)
      check($sformatf("ff frame %0d", f), 64'(rx_frame[f]), 64'({3'(f), 18'h3FFFF}));
    check("ff frame count", 64'(rx_cnt), 64'd8);
    check("ff done edge", 64'(dut_done_edge), 64'd194);
    check("ff frame1 start", 64'(rx_start[1]), 64'd41);
    check("ff frame7 start", 64'(rx_start[7]), 64'd173);

    // All words 01: only frame 0 carries data.
    for (int i = 0; i < NW; i++) mem[i] = 8'h01;
    build_model();
    run(0);
    check("01 frame 0", 64'(rx_frame[0]), 64'h03FFFF);
    check("01 frame 3", 64'(rx_frame[3]), 64'h0C0000);
    check("01 frame 7", 64'(rx_frame[7]), 64'h1C0000);

    // Single set bit: word 17 bit 7 lands in frame 7 data MSB.
    for (int i = 0; i < NW; i++) mem[i] = 8'h00;
    mem[17] = 8'h80;
    build_model();
    run(0);
    check("msb frame 7", 64'(rx_frame[7]), 64'h1E0000);
    check("msb frame 6", 64'(rx_frame[6]), 64'h180000);
    check("msb frame 0", 64'(rx_frame[0]), 64'h000000);

    // Hold across the launch of frame 3 delays it and done by five cycles.
    for (int i = 0; i < NW; i++) mem[i] = 8'(32'($urandom));
    clear_hold();
    for (int e = 85; e <= 89; e++) hold_at[e] = 1'b1;
    build_model();
    run(0);
    check("hold frame3 start", 64'(rx_start[3]), 64'd90);
    check("hold frame2 start", 64'(rx_start[2]), 64'd63);
    check("hold done edge", 64'(dut_done_edge), 64'd199);

    // Hold during load and frame bits is ignored.
    clear_hold();
    for (int e = 3; e <= 12; e++) hold_at[e] = 1'b1;
    for (int e = 20; e <= 38; e++) hold_at[e] = 1'b1;
    for (int e = 44; e <= 60; e++) hold_at[e] = 1'b1;
    build_model();
    run(0);
    check("ignored hold done edge", 64'(dut_done_edge), 64'd194);

    // Reset in the middle of frame 3, then a clean full sequence.
    clear_hold();
    build_model();
    run(100);
    #7;
    check_reset("reset held low");
    run(0);
    check("after reset done edge", 64'(dut_done_edge), 64'd194);
    for (int f = 0; f < NF; f++)
      check($sformatf("after reset frame %0d", f), 64'(rx_frame[f]), 64'(model_frame[f]));

    // Random bank contents and random hold pattern.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NW; i++) mem[i] = 8'($urandom_range(0, 255));
      clear_hold();
      for (int e = 1; e < 400; e++) hold_at[e] = ($urandom_range(0, 3) == 0);
      build_model();
      run(0);
      for (int f = 0; f < NF; f++) begin
        check($sformatf("rand %0d frame %0d", t, f), 64'(rx_frame[f]), 64'(model_frame[f]));
        check($sformatf("rand %0d start %0d", t, f), 64'(rx_start[f]), 64'(model_start[f]));
      end
      check($sformatf("rand %0d done edge", t), 64'(dut_done_edge), 64'(model_done_edge));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/s1_frame_tx.md
# s1_frame_tx

Serial frame transmitter that sequences the S2 serial link. After reset it reads an 18-word × 8-bit source register bank (RB1) into an internal buffer. It transposes the buffer into eight 21-bit frames and shifts them out on `sen`/`sd`, where the S2 receiver rebuilds them into RB2. It drives RB1 as its only master, paces frames with a programmable inter-frame gap and a `hold` back-pressure input, and raises `S1_done` when the last frame has been sent.

## Interface
- `NWORD`, 18: RB1 words read; also the frame data width.
- `NFRAME`, 8: frames sent; also the RB1 word width.
- `GAP`, 1: minimum cycles with `sen`=1 between frames, ≥1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `RB1_RW` output 1: RB1 read/write; held 1 (read) at all times.
- `RB1_A` output 5: RB1 word address.
- `RB1_Q` input 8: RB1 read data, valid one cycle after `RB1_A`.
- `hold` input 1: downstream back-pressure; sampled only in the gap.
- `sen` output 1: frame enable, active-low, low for exactly 21 cycles per frame.
- `sd` output 1: serial data, MSB first.
- `S1_done` output 1: all frames sent; sticky until reset.

## Operation
- Reset values (while `rst`=0, asynchronous):
  - `RB1_RW`=1, `RB1_A`=0, `sen`=1, `sd`=0, `S1_done`=0.
  - Buffer cleared, state LOAD.
- States:
  - LOAD → TX after word NWORD-1 is captured.
  - TX → GAP after the 21st bit of a frame.
  - GAP → TX when the gap count is met and `hold`=0, if frames remain.
  - TX → DONE after the last bit of frame NFRAME-1.
  - DONE is terminal.
- LOAD:
  - At edge k (k=1..NWORD) after release, capture `RB1_Q` as word k-1.
  - `RB1_A` increments to k and saturates at NWORD-1.
- Transpose: data bit w of frame f is bit f of word w (D_w = RB1[w][f]).
- Frame format for frame f:
  - 21 bits, {f[2:0], D17..D0}.
  - `sd` carries bit 20 first and bit 0 last.
  - `sen`=0 for all 21 bits.
- GAP:
  - `sen`=1, `sd`=0 for GAP cycles.
  - At each later edge, if `hold`=1 the block stays in GAP.
  - The next frame starts at the first edge where the gap count is met and `hold`=0.
  - `hold` is ignored in LOAD, TX and DONE; a frame, once started, is never interrupted.
- DONE:
  - Entered on the edge after the last bit of frame NFRAME-1.
  - Sets `S1_done`=1, `sen`=1, `sd`=0.
  - No gap after the last frame; all outputs hold until reset.
- Widths and counters:
  - Frame counter is 3 bits, bit counter 5 bits (20 down to 0), gap counter sized for GAP.
  - Frame index f is driven in the address field without wrap (f ≤ 7).
- Reset mid-operation: all outputs and state return to reset values immediately, the buffer is cleared, and the full sequence restarts from LOAD on release.

## Timing
- Edge numbering: edge 1 is the first rising edge after `rst` goes high.
- Load: edges 1..18 capture words 0..17 (19 address cycles including reset).
- Frame f (with `hold` low throughout) is driven on edges 19+(21+GAP)·f through that value +20.
- With GAP=1:
  - frame 0 on edges 19..39, gap at edge 40, frame 1 starts at edge 41;
  - frame 7 on edges 173..193;
  - `S1_done` rises at edge 194.
- Each cycle `hold` is sampled high at a gap-end edge delays every later frame, and `S1_done`, by exactly one cycle.
- Outputs are registered; `sd` changes only on rising edges, aligned with `sen`.

## Test plan
- All RB1 words 8'hFF, `hold`=0:
  - every frame carries {f, 18'h3FFFF};
  - `sen` pattern is 21 low / 1 high ×8;
  - `S1_done` rises at edge 194.
- All RB1 words 8'h01:
  - frame 0 = 21'h03FFFF;
  - frames 1..7 carry data 0, e.g. frame 7 = 21'h1C0000.
- RB1[17]=8'h80, all others 0:
  - frame 7 = 21'h1E0000;
  - all other frames have zero data.
- `hold`=1 at edges 85..89 (gap after frame 2, GAP=1):
  - frame 3 starts at edge 90 instead of 85;
  - `S1_done` rises at edge 199.
- `hold` pulsed high during frame bits and during LOAD:
  - no effect on any output;
  - `S1_done` still rises at edge 194.
- `rst` pulled low at edge 100 (mid-frame 3):
  - `sen`=1, `sd`=0, `RB1_A`=0, `S1_done`=0 immediately, without waiting for a clock edge;
  - after release, the sequence repeats and `S1_done` rises at edge 194 relative to the new release.
